approx_mul_err_sweeper: RTL and testbench

- Downstream measurement stage for the 8x8 GenMul approximate multipliers, e.g. the Dadda tree built with approx_fa_2_126.
- Exhaustively sweeps every operand pair and drives the operands into a purely combinational approximate multiplier.
- Samples the returned product in the same cycle, computes the exact product internally, and accumulates error metrics for MAE and worst-case characterisation.
- Results are read once done is high.

---
 rtl/approx_mul_err_sweeper.sv | 167 ++++++++++++++++
 tb/tb_approx_mul_err_sweeper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_sweeper.sv
// Exhaustive error sweeper for an 8x8 combinational approximate multiplier: drives every operand pair
// and accumulates SAE, max error (with first worst pair), error count and, with ERR_SSE_EN, SSE.
//
// state | meaning
// IDLE  | waiting for start; results from an aborted run are held
// SWEEP | presenting one operand pair per cycle, op_a fastest
// DRAIN | two cycles letting both pipeline stages retire
// DONE  | results valid and held until the next start
module approx_mul_err_sweeper #(
  parameter int WIDTH = 8,
  parameter int SAE_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic [WIDTH-1:0]             op_a,
  output logic [WIDTH-1:0]             op_b,
  input  logic [2*WIDTH-1:0]           prod_in,
  output logic                         busy,
  output logic                         done,
  output logic [SAE_W-1:0]             sae,
  output logic [2*WIDTH-1:0]           max_err,
  output logic [WIDTH-1:0]             worst_a,
  output logic [WIDTH-1:0]             worst_b,
  output logic [2*WIDTH:0]             err_cnt,
  output logic [2*SAE_W-2*WIDTH-1:0]   sse
);

  localparam int PW    = 2 * WIDTH;
  localparam int CW    = PW + 1;
  localparam int SSE_W = 2 * SAE_W - 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     cnt;
  logic              drain_left;
  logic              start_acc;
  logic              abort_acc;

  logic              s1_valid;
  logic [PW-1:0]     s1_prod;
  logic [PW-1:0]     s1_exact;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic [PW-1:0]     err;

  assign op_a = cnt[WIDTH-1:0];
  assign op_b = cnt[PW-1:WIDTH];
  assign busy = (state == S_SWEEP) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    abort_acc = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (abort) begin
          abort_acc = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == {PW{1'b1}}) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          abort_acc = 1'b1;
          state_nxt = S_IDLE;
        end else if (!drain_left) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      drain_left <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        cnt <= '0;
      end else if (state == S_SWEEP && !abort_acc) begin
        cnt <= cnt + 1'b1;  // wraps to 0 after the all-ones pair
      end
      if (state == S_SWEEP) begin
        drain_left <= 1'b1;
      end else if (drain_left) begin
        drain_left <= drain_left - 1'b1;
      end
    end
  end

  // Stage 1: capture the returned product alongside the exact one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_exact <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= (state == S_SWEEP) && !abort_acc;
      s1_prod  <= prod_in;
      s1_exact <= {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
      s1_a     <= op_a;
      s1_b     <= op_b;
    end
  end

  assign err = (s1_prod > s1_exact) ? (s1_prod - s1_exact) : (s1_exact - s1_prod);

  // Stage 2: accumulate; strict compare keeps the earliest worst pair on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sae     <= '0;
      max_err <= '0;
      worst_a <= '0;
      worst_b <= '0;
      err_cnt <= '0;
    end else if (start_acc) begin
      sae     <= '0;
      max_err <= '0;
      worst_a <= '0;
      worst_b <= '0;
      err_cnt <= '0;
    end else if (s1_valid) begin
      sae     <= sae + SAE_W'(err);
      err_cnt <= err_cnt + CW'(err != '0);
      if (err > max_err) begin
        max_err <= err;
        worst_a <= s1_a;
        worst_b <= s1_b;
      end
    end
  end

`ifdef ERR_SSE_EN
  logic [2*PW-1:0] err_sq;

  assign err_sq = {{PW{1'b0}}, err} * {{PW{1'b0}}, err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sse <= '0;
    end else if (start_acc) begin
      sse <= '0;
    end else if (s1_valid) begin
      sse <= sse + SSE_W'(err_sq);
    end
  end
`else
  assign sse = '0;
`endif

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Directed bench for approx_mul_err_sweeper, run at WIDTH=4 (256 pairs, start-to-done latency 258)
// so several full sweeps fit in a short run; a small behavioural multiplier sits on prod_in.
module tb_approx_mul_err_sweeper;

  localparam int W     = 4;
  localparam int SW    = 16;
  localparam int PW    = 2 * W;
  localparam int SSEW  = 2 * SW - 2 * W;
  localparam int LAT   = (1 << PW) + 2;
`ifdef ERR_SSE_EN
  localparam bit SSE_ON = 1'b1;
`else
  localparam bit SSE_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [PW-1:0]   prod_in;
  logic            busy;
  logic            done;
  logic [SW-1:0]   sae;
  logic [PW-1:0]   max_err;
  logic [W-1:0]    worst_a;
  logic [W-1:0]    worst_b;
  logic [PW:0]     err_cnt;
  logic [SSEW-1:0] sse;

  int mode;
  int errors;
  int checks;
  int n;

  approx_mul_err_sweeper #(.WIDTH(W), .SAE_W(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .op_a    (op_a),
    .op_b    (op_b),
    .prod_in (prod_in),
    .busy    (busy),
    .done    (done),
    .sae     (sae),
    .max_err (max_err),
    .worst_a (worst_a),
    .worst_b (worst_b),
    .err_cnt (err_cnt),
    .sse     (sse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mode 0: exact, 1: exact with LSB flipped, 2: exact except (15,15) returns 0
  always_comb begin
    logic [PW-1:0] exact;
    exact = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    prod_in = exact;
    case (mode)
      1: prod_in = exact ^ {{(PW-1){1'b0}}, 1'b1};
      2: if (op_a == {W{1'b1}} && op_b == {W{1'b1}}) prod_in = '0;
      default: prod_in = exact;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input int esae, input int ecnt, input int emax,
                               input int ewa, input int ewb, input longint esse);
    check({tag, ".sae"}, 64'(sae), 64'(esae));
    check({tag, ".err_cnt"}, 64'(err_cnt), 64'(ecnt));
    check({tag, ".max_err"}, 64'(max_err), 64'(emax));
    check({tag, ".worst_a"}, 64'(worst_a), 64'(ewa));
    check({tag, ".worst_b"}, 64'(worst_b), 64'(ewb));
    check({tag, ".sse"}, 64'(sse), SSE_ON ? 64'(esse) : 64'd0);
  endtask

  // Called at a negedge; pulses start and counts edges until done rises (bounded).
  task automatic start_and_wait(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(LAT));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mode   = 0;
    start  = 1'b0;
    abort  = 1'b0;
    rst_n  = 1'b0;
    #23;
    check("rst.op_a", 64'(op_a), 64'd0);
    check("rst.op_b", 64'(op_b), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check_results("rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    mode = 0;
    start_and_wait("exact");
    check_results("exact", 0, 0, 0, 0, 0, 0);
    check("exact.op_a_done", 64'(op_a), 64'd0);
    check("exact.op_b_done", 64'(op_b), 64'd0);

    mode = 1;
    start_and_wait("lsb");
    check_results("lsb", 256, 256, 1, 0, 0, 256);

    mode = 2;
    start_and_wait("corner");
    check_results("corner", 225, 1, 225, 15, 15, 50625);
    repeat (5) @(negedge clk);
    check("corner.done_hold", 64'(done), 64'd1);
    check("corner.sae_hold", 64'(sae), 64'd225);

    // abort sampled at the 100th SWEEP edge: pairs 0..98 have retired
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.sae", 64'(sae), 64'd99);
    check("abort.err_cnt", 64'(err_cnt), 64'd99);
    check("abort.max_err", 64'(max_err), 64'd1);
    repeat (16) @(negedge clk);
    check("abort.sae_frozen", 64'(sae), 64'd99);
    check("abort.done_frozen", 64'(done), 64'd0);
    mode = 0;
    start_and_wait("restart");
    check_results("restart", 0, 0, 0, 0, 0, 0);

    // start and abort together while sweeping
    repeat (16) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("both.busy", 64'(busy), 64'd0);
    check("both.done", 64'(done), 64'd0);

    // start held high through the sweep must not restart it
    repeat (16) @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("held.latency", 64'(n), 64'(LAT));
    check_results("held", 256, 256, 1, 0, 0, 256);
    @(negedge clk);
    check("held.done_after", 64'(done), 64'd1);

    // asynchronous reset mid-sweep, off the clock edges
    start_and_wait("pre_rst");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.done", 64'(done), 64'd0);
    check("arst.op_a", 64'(op_a), 64'd0);
    check("arst.op_b", 64'(op_b), 64'd0);
    check_results("arst", 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    start_and_wait("post_rst");
    check_results("post_rst", 256, 256, 1, 0, 0, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
